// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Two-requester shared add/subtract unit. A three-state FSM
// (IDLE -> EXEC -> RESP -> IDLE) picks one requester in IDLE, captures its
// operands, computes A+B or A-B during EXEC and presents the registered
// result and signed-overflow flag from RESP onwards. Simultaneous requests
// are arbitrated round-robin (requester 0 wins first after reset).
//
// Build option:
//   ADDSUB_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie and
//                             the last-granted pointer is not built.
//
// Ports:
//   clk          in   clock, rising edge active
//   rst_n        in   asynchronous active-low reset
//   req0/req1    in   operation request from requester 0/1
//   a0/a1,b0/b1  in   [WIDTH] two's-complement operands of requester 0/1
//   m0/m1        in   mode of requester 0/1: 0 = A+B, 1 = A-B
//   gnt0/gnt1    out  pulse during EXEC: operands of requester 0/1 captured
//   done0/done1  out  pulse during RESP: result/ovf belong to requester 0/1
//   result       out  [WIDTH] registered sum or difference
//   ovf          out  registered signed-overflow flag
//   busy         out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module addsub_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             m0,
   input  logic             m1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic             capture;
   logic             winner;          // 0 = requester 0, 1 = requester 1
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             m_reg;
   logic             id_reg;
   logic [WIDTH-1:0] result_reg;
   logic             ovf_reg;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
   // Requester 0 always wins; requester 1 only when it asks alone.
   assign winner = ~req0;
`else
   logic last_reg;

   // On a tie, grant the requester that did not win last time.
   assign winner = (req0 && req1) ? ~last_reg : req1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_reg <= 1'b1;
      end else if (capture) begin
         last_reg <= winner;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               state_next = EXEC;
               capture    = 1'b1;
            end
         end
         EXEC: begin
            gnt0       = ~id_reg;
            gnt1       = id_reg;
            state_next = RESP;
         end
         RESP: begin
            done0      = ~id_reg;
            done1      = id_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: subtraction is A + ~B + 1, so one adder serves both modes.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] b_x;
   logic [WIDTH:0]   sum_full;
   logic             carry_in_msb;

   assign b_x      = b_reg ^ {WIDTH{m_reg}};
   assign sum_full = {1'b0, a_reg} + {1'b0, b_x} + {{WIDTH{1'b0}}, m_reg};
   // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
   // of the full sum without a second adder.
   assign carry_in_msb = sum_full[WIDTH-1] ^ a_reg[WIDTH-1] ^ b_x[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         m_reg      <= 1'b0;
         id_reg     <= 1'b0;
         result_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (capture) begin
            a_reg  <= winner ? a1 : a0;
            b_reg  <= winner ? b1 : b0;
            m_reg  <= winner ? m1 : m0;
            id_reg <= winner;
         end
         if (state_reg == EXEC) begin
            result_reg <= sum_full[WIDTH-1:0];
            ovf_reg    <= carry_in_msb ^ sum_full[WIDTH];
         end
      end
   end

   assign result = result_reg;
   assign ovf    = ovf_reg;

endmodule
